// File: rtl/sram_pkg.sv
// Shared types and helpers for the dual-port byte-enable SRAM.
// Clear-FSM states, byte width, legal read latencies, parity helper.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_e;

    localparam int BYTE_W = 8;

    localparam int RL_MIN = 1;
    localparam int RL_MAX = 2;

    // Upper bound for the generic parity helper; callers zero-extend.
    localparam int PAR_MAX_W = 1024;
    localparam int PAR_MAX_B = PAR_MAX_W / BYTE_W;

    // Even parity of every byte of d.
    function automatic logic [PAR_MAX_B-1:0] byte_parity(
        input logic [PAR_MAX_W-1:0] d
    );
        logic [PAR_MAX_B-1:0] p;
        for (int i = 0; i < PAR_MAX_B; i++) begin
            p[i] = ^d[i*BYTE_W +: BYTE_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/sram_init_fsm.sv
// Clear-after-reset sequencer: zeroes every word once, then idles.
// Ports: clk, rst, clr_we/clr_addr (clear write strobe), init_busy.
module sram_init_fsm
    import sram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_busy
);

    init_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              init_busy_q, init_busy_d;

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        init_busy_d = init_busy_q;
        unique case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d     = READY;
                    init_busy_d = 1'b0;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign clr_we    = (state_q == CLEAR);
    assign clr_addr  = clr_addr_q;
    assign init_busy = init_busy_q;

endmodule

// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM, byte write enables, 1/2-cycle read latency.
// Ports: wr_* write port, rd_* read port, init_busy during clear.
// Option SRAM_DP_PARITY_EN adds per-byte parity, par_inject, par_err.
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1,
    parameter int WR_FIRST     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
`ifdef SRAM_DP_PARITY_EN
    input  logic                     par_inject,
    output logic                     par_err,
`endif
    output logic                     init_busy
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    if ((DATA_W % BYTE_W) != 0) begin : g_err_dw
        $fatal(1, "sram_dp_be: DATA_W must be a multiple of 8");
    end
    if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_err_rl
        $fatal(1, "sram_dp_be: READ_LATENCY must be 1 or 2");
    end

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    sram_init_fsm #(
        .ADDR_W (ADDR_W)
    ) u_init (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok;
    logic              rd_ok;
    logic              hit;
    logic [DATA_W-1:0] rd_word;

    assign wr_ok = wr_en & ~init_busy;
    assign rd_ok = rd_en & ~init_busy;
    assign hit   = wr_ok & rd_ok & (wr_addr == rd_addr);

    // Write-first bypass: merge enabled write bytes over the old word.
    always_comb begin
        rd_word = mem[rd_addr];
        if (WR_FIRST != 0 && hit) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    rd_word[i*BYTE_W +: BYTE_W] =
                        wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_W +: BYTE_W] <=
                        wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

`ifdef SRAM_DP_PARITY_EN
    if (DATA_W >= PAR_MAX_W) begin : g_err_pw
        $fatal(1, "sram_dp_be: DATA_W too wide for parity helper");
    end

    logic [NB-1:0]        par_mem [DEPTH];
    logic [PAR_MAX_B-1:0] wr_par_full;
    logic [PAR_MAX_B-1:0] rd_chk_full;
    logic [NB-1:0]        wr_par;
    logic [NB-1:0]        rd_par;
    logic                 rd_perr;
    logic                 unused_par;

    always_comb begin
        wr_par_full = byte_parity(PAR_MAX_W'(wr_data));
        wr_par      = wr_par_full[NB-1:0];
        wr_par[0]   = wr_par[0] ^ par_inject;
    end

    always_comb begin
        rd_par = par_mem[rd_addr];
        if (WR_FIRST != 0 && hit) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    rd_par[i] = wr_par[i];
                end
            end
        end
        rd_chk_full = byte_parity(PAR_MAX_W'(rd_word));
        rd_perr     = |(rd_chk_full[NB-1:0] ^ rd_par);
    end

    assign unused_par = ^{wr_par_full[PAR_MAX_B-1:NB],
                          rd_chk_full[PAR_MAX_B-1:NB]};

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    par_mem[wr_addr][i] <= wr_par[i];
                end
            end
        end
    end
`endif

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
`ifdef SRAM_DP_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    if (READ_LATENCY == 1) begin : g_rl1
        always_comb begin
            rd_valid_d = rd_ok;
            rd_data_d  = rd_ok ? rd_word : rd_data_q;
`ifdef SRAM_DP_PARITY_EN
            par_err_d  = rd_ok & rd_perr;
`endif
        end
    end else begin : g_rl2
        logic              p_valid_q;
        logic [DATA_W-1:0] p_data_q;
`ifdef SRAM_DP_PARITY_EN
        logic              p_perr_q;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p_valid_q <= 1'b0;
                p_data_q  <= '0;
`ifdef SRAM_DP_PARITY_EN
                p_perr_q  <= 1'b0;
`endif
            end else begin
                p_valid_q <= rd_ok;
                p_data_q  <= rd_word;
`ifdef SRAM_DP_PARITY_EN
                p_perr_q  <= rd_perr;
`endif
            end
        end

        always_comb begin
            rd_valid_d = p_valid_q;
            rd_data_d  = p_valid_q ? p_data_q : rd_data_q;
`ifdef SRAM_DP_PARITY_EN
            par_err_d  = p_valid_q & p_perr_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef SRAM_DP_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef SRAM_DP_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`ifdef SRAM_DP_PARITY_EN
    assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_sram_dp_be.sv
// Bench for sram_dp_be: two instances (RL1/write-first, RL2/read-first)
// on shared stimulus, checked against an array-based model.
module tb_sram_dp_be;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic        par_inject = 1'b0;

    logic [31:0] d1, d2;
    logic        v1, v2, b1, b2;
    logic        pe1, pe2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_dp_be #(
        .DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .WR_FIRST(1)
    ) u_d1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1),
`ifdef SRAM_DP_PARITY_EN
        .par_inject(par_inject), .par_err(pe1),
`endif
        .init_busy(b1)
    );

    sram_dp_be #(
        .DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .WR_FIRST(0)
    ) u_d2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(d2), .rd_valid(v2),
`ifdef SRAM_DP_PARITY_EN
        .par_inject(par_inject), .par_err(pe2),
`endif
        .init_busy(b2)
    );

`ifndef SRAM_DP_PARITY_EN
    assign pe1 = 1'b0;
    assign pe2 = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    // Model: memory array, clear counter, and results scheduled by edge.
    logic [31:0] mmem [16];
    bit          corrupt [16];
    int          clr_cnt = 0;
    int          ecnt = 0;
    logic [31:0] exp1 [int];
    logic [31:0] exp2 [int];
    bit          perr1 [int];
    bit          perr2 [int];
    logic [31:0] m_d1 = '0, m_d2 = '0;
    logic        m_v1 = 1'b0, m_v2 = 1'b0;
    logic        m_p1 = 1'b0, m_p2 = 1'b0;
    logic        m_busy = 1'b1;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mmem[i] = '0;
            corrupt[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        logic [31:0] old_w, new_w;
        bit          c_old, c_new;
        bit          hit;
        ecnt++;
        if (rst) begin
            clr_cnt = 0;
            exp1.delete(); exp2.delete();
            perr1.delete(); perr2.delete();
            m_d1 = '0; m_d2 = '0;
            m_v1 = 1'b0; m_v2 = 1'b0;
            m_p1 = 1'b0; m_p2 = 1'b0;
        end else begin
            if (clr_cnt < 16) begin
                mmem[clr_cnt] = '0;
                corrupt[clr_cnt] = 1'b0;
                clr_cnt++;
            end else begin
                hit = wr_en && rd_en && (wr_addr == rd_addr);
                if (rd_en) begin
                    old_w = mmem[rd_addr];
                    c_old = corrupt[rd_addr];
                    new_w = hit ? merge(old_w, wr_data, wr_be) : old_w;
                    c_new = (hit && wr_be[0]) ? par_inject : c_old;
                    exp1[ecnt]   = new_w;
                    perr1[ecnt]  = c_new;
                    exp2[ecnt+1] = old_w;
                    perr2[ecnt+1] = c_old;
                end
                if (wr_en) begin
                    mmem[wr_addr] = merge(mmem[wr_addr], wr_data, wr_be);
                    if (wr_be[0]) corrupt[wr_addr] = par_inject;
                end
            end
            m_v1 = exp1.exists(ecnt);
            m_p1 = 1'b0;
            if (m_v1) begin
                m_d1 = exp1[ecnt];
                m_p1 = perr1[ecnt];
                exp1.delete(ecnt);
            end
            m_v2 = exp2.exists(ecnt);
            m_p2 = 1'b0;
            if (m_v2) begin
                m_d2 = exp2[ecnt];
                m_p2 = perr2[ecnt];
                exp2.delete(ecnt);
            end
        end
        m_busy = (clr_cnt < 16);
    end

    always @(negedge clk) begin
        chk("init_busy1", 32'(b1), 32'(m_busy));
        chk("init_busy2", 32'(b2), 32'(m_busy));
        chk("rd_valid1", 32'(v1), 32'(m_v1));
        chk("rd_data1", d1, m_d1);
        chk("rd_valid2", 32'(v2), 32'(m_v2));
        chk("rd_data2", d2, m_d2);
`ifdef SRAM_DP_PARITY_EN
        chk("par_err1", 32'(pe1), 32'(m_p1));
        chk("par_err2", 32'(pe2), 32'(m_p2));
`endif
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; par_inject = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
    endtask

    // Release reset (if held) and count cycles init_busy stays high.
    task automatic count_busy(output int cnt, output int vseen);
        cnt = 0; vseen = 0;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b1) cnt++;
            if (v1 || v2) vseen++;
            if (i == 3) begin wr(4'd7, 32'hFFFF_FFFF, 4'hF); rd(4'd7); end
            tick();
            idle();
        end
    endtask

    initial begin
        int bc, vs;
        tick(); tick(); tick();

        count_busy(bc, vs);
        chk("busy_cycles", 32'(bc), 32'd16);
        chk("no_valid_busy", 32'(vs), 32'd0);

        for (int a = 0; a < 16; a++) begin
            rd(4'(a)); tick();
            chk("clear_rd_valid", 32'(v1), 32'd1);
            chk("clear_rd_data", d1, 32'h0);
        end
        idle(); tick();

        wr(4'd3, 32'hDEAD_BEEF, 4'b1111); tick();
        wr(4'd3, 32'h1122_3344, 4'b0101); tick();
        idle(); rd(4'd3); tick();
        idle();
        chk("be_merge_v1", 32'(v1), 32'd1);
        chk("be_merge_d1", d1, 32'hDE22_BE44);
        tick();
        chk("be_merge_d2", d2, 32'hDE22_BE44);

        wr(4'd5, 32'hAAAA_AAAA, 4'hF); tick();
        wr(4'd5, 32'h5555_5555, 4'b0011); rd(4'd5); tick();
        idle();
        chk("coll_wrfirst", d1, 32'hAAAA_5555);
        tick();
        chk("coll_rdfirst", d2, 32'hAAAA_AAAA);
        rd(4'd5); tick(); idle();
        chk("after_coll_d1", d1, 32'hAAAA_5555);
        tick();
        chk("after_coll_d2", d2, 32'hAAAA_5555);

        for (int a = 0; a < 3; a++) begin
            wr(4'(a), 32'h100 + 32'(a), 4'hF); tick();
        end
        idle();
        rd(4'd0); tick();
        chk("rl2_v_a", 32'(v2), 32'd0);
        rd(4'd1); tick();
        chk("rl2_v_b", 32'(v2), 32'd1);
        chk("rl2_d_b", d2, 32'h100);
        rd(4'd2); tick();
        idle();
        chk("rl2_v_c", 32'(v2), 32'd1);
        chk("rl2_d_c", d2, 32'h101);
        tick();
        chk("rl2_v_d", 32'(v2), 32'd1);
        chk("rl2_d_d", d2, 32'h102);
        tick();
        chk("rl2_v_e", 32'(v2), 32'd0);
        chk("rl2_hold", d2, 32'h102);

        rst = 1'b1; tick(); rst = 1'b0;
        repeat (7) tick();
        rst = 1'b1; tick();
        count_busy(bc, vs);
        chk("busy_after_midclr", 32'(bc), 32'd16);
        chk("no_valid_midclr", 32'(vs), 32'd0);

        wr(4'd4, 32'hCAFE_F00D, 4'hF); tick();
        idle(); rd(4'd4); tick();
        idle(); rst = 1'b1; tick();
        chk("flush_v1", 32'(v1), 32'd0);
        chk("flush_v2", 32'(v2), 32'd0);
        chk("flush_d2", d2, 32'h0);
        count_busy(bc, vs);
        chk("busy_after_flush", 32'(bc), 32'd16);
        chk("no_valid_flush", 32'(vs), 32'd0);

`ifdef SRAM_DP_PARITY_EN
        wr(4'd9, 32'h0000_00FF, 4'hF); par_inject = 1'b1; tick();
        idle(); rd(4'd9); tick(); idle();
        chk("par_inj_v", 32'(v1), 32'd1);
        chk("par_inj_err", 32'(pe1), 32'd1);
        wr(4'd9, 32'h0000_00FF, 4'hF); tick();
        idle(); rd(4'd9); tick(); idle();
        chk("par_clean_err", 32'(pe1), 32'd0);
`endif

        for (int c = 0; c < 500; c++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            rd_en   = ($urandom_range(0, 2) != 0);
            wr_addr = 4'($urandom_range(0, 15));
            rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr
                                                  : 4'($urandom_range(0, 15));
            wr_be   = 4'($urandom_range(0, 15));
            wr_data = $urandom;
`ifdef SRAM_DP_PARITY_EN
            par_inject = ($urandom_range(0, 7) == 0);
`endif
            if (c == 250) rst = 1'b1;
            if (c == 251) rst = 1'b0;
            tick();
        end
        idle();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
